// File: rtl/seg7_pkg.sv
// seg7_pkg: hex glyph table and sizing helper shared by the seven-segment display blocks
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int digits_for(input int width);
        return (width + 3) / 4;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-high seven-segment decoder with blanking
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_OFF : GLYPH[hex];

endmodule

// File: rtl/sum_seg7_scan.sv
// sum_seg7_scan: registered adder with a tear-free multiplexed hex seven-segment display
module sum_seg7_scan
    import seg7_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  load,
    output logic [WIDTH:0]        sum,
    output logic                  sum_valid,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] SEG_INV = ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_INV = {NUM_DIGITS{ACTIVE_LOW != 0}};

    if (NUM_DIGITS < digits_for(WIDTH + 1) || REFRESH_DIV < 2) begin : g_bad_params
        $error("sum_seg7_scan: NUM_DIGITS too small for WIDTH or REFRESH_DIV < 2");
    end

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] snap;
    logic                    tc;
    logic                    wrap;
    logic [3:0]              nib;
    logic                    blank;
    logic [6:0]              glyph;

    assign tc    = cnt == CW'(REFRESH_DIV - 1);
    assign wrap  = tc && idx == IW'(NUM_DIGITS - 1);
    assign nib   = 4'(snap >> {idx, 2'b00});
    // a digit is blank when it and every digit above it are zero
    assign blank = BLANK_LZ != 0 && idx != '0 && (snap >> {idx, 2'b00}) == '0;

    hex_to_seg7 u_dec (
        .hex   (nib),
        .blank (blank),
        .seg   (glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            sum_valid <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            snap      <= '0;
            seg       <= SEG_OFF ^ SEG_INV;
            an        <= AN_INV;
        end else begin
            if (load) sum <= {1'b0, a} + {1'b0, b};
            sum_valid <= load;
            cnt       <= tc ? '0 : cnt + 1'b1;
            if (tc) idx <= wrap ? '0 : idx + 1'b1;
            // snapshot only at frame start so a frame never mixes two sums
            if (wrap) snap <= (4*NUM_DIGITS)'(sum);
            seg       <= glyph ^ SEG_INV;
            an        <= (NUM_DIGITS'(1) << idx) ^ AN_INV;
        end
    end

endmodule

// File: tb/tb_sum_seg7_scan.sv
// tb_sum_seg7_scan: directed self-checking bench for the adder and scanned display
module tb_sum_seg7_scan;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       load;
    logic [8:0] sum;
    logic       sum_valid;
    logic [6:0] seg;
    logic [3:0] an;

    int errs   = 0;
    int checks = 0;

    sum_seg7_scan #(
        .WIDTH       (8),
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1),
        .BLANK_LZ    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .load      (load),
        .sum       (sum),
        .sum_valid (sum_valid),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] v);
        int n = 0;
        while (an !== v && n < 40) begin
            tick();
            n++;
        end
        check("wait_an", 32'(an), 32'(v));
    endtask

    // walks one whole frame, checking every cycle of every digit slot
    task automatic show_frame(input string tag, input bit sync,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] e [4];
        logic [3:0] ea;
        e = '{s0, s1, s2, s3};
        if (sync) begin
            wait_an(4'h7);
            wait_an(4'hE);
        end
        for (int d = 0; d < 4; d++) begin
            ea = ~(4'b0001 << d);
            for (int c = 0; c < 4; c++) begin
                check({tag, "_an"}, 32'(an), 32'(ea));
                check({tag, "_seg"}, 32'(seg), 32'(e[d]));
                tick();
            end
        end
    endtask

    task automatic do_load(input logic [7:0] va, input logic [7:0] vb);
        a = va;
        b = vb;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        a    = '0;
        b    = '0;
        repeat (3) tick();
        check("rst_seg", 32'(seg), 'h7F);
        check("rst_an", 32'(an), 'hF);
        check("rst_sum", 32'(sum), 'h0);
        check("rst_valid", 32'(sum_valid), 'h0);
        rst = 1'b0;
        tick();
        check("first_an", 32'(an), 'hE);
        check("first_seg", 32'(seg), 'h40);
        show_frame("zero", 1'b1, 7'h40, 7'h7F, 7'h7F, 7'h7F);

        do_load(8'hFF, 8'h01);
        check("carry_sum", 32'(sum), 'h100);
        check("carry_valid", 32'(sum_valid), 'h1);
        tick();
        check("carry_pulse", 32'(sum_valid), 'h0);
        show_frame("carry", 1'b1, 7'h40, 7'h40, 7'h79, 7'h7F);

        do_load(8'hFF, 8'hA4);
        check("scan_sum", 32'(sum), 'h1A3);
        show_frame("scan", 1'b1, 7'h30, 7'h08, 7'h79, 7'h7F);

        wait_an(4'h7);
        repeat (2) tick();
        do_load(8'h12, 8'h34);
        check("tear_sum", 32'(sum), 'h46);
        check("tear_an_pre", 32'(an), 'h7);
        tick();
        show_frame("tear_old", 1'b0, 7'h30, 7'h08, 7'h79, 7'h7F);
        show_frame("tear_new", 1'b0, 7'h02, 7'h19, 7'h7F, 7'h7F);

        wait_an(4'hB);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_an", 32'(an), 'hF);
        check("mrst_seg", 32'(seg), 'h7F);
        check("mrst_sum", 32'(sum), 'h0);
        check("mrst_valid", 32'(sum_valid), 'h0);
        tick();
        show_frame("mrst", 1'b0, 7'h40, 7'h7F, 7'h7F, 7'h7F);

        a = 8'h02;
        b = 8'h03;
        load = 1'b1;
        tick();
        check("b2b_sum1", 32'(sum), 'h05);
        check("b2b_valid1", 32'(sum_valid), 'h1);
        a = 8'h04;
        b = 8'h06;
        tick();
        load = 1'b0;
        check("b2b_sum2", 32'(sum), 'h0A);
        check("b2b_valid2", 32'(sum_valid), 'h1);
        tick();
        check("b2b_valid_end", 32'(sum_valid), 'h0);
        check("b2b_sum_end", 32'(sum), 'h0A);
        show_frame("b2b", 1'b1, 7'h08, 7'h7F, 7'h7F, 7'h7F);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
